stg1fq: RTL and testbench

STG1FQ -- requirements
Module: stg1fq

---
 rtl/stg1fq_pkg.sv | 8 +
 rtl/stg1fq.sv | 69 ++++++
 tb/tb_stg1fq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/stg1fq_pkg.sv
// stg1fq_pkg: shared fetch-queue sizes (address/data widths, default queue depth)
package stg1fq_pkg;
    localparam int SIZE_ADDR = 32;
    localparam int HBIT_ADDR = SIZE_ADDR - 1;
    localparam int SIZE_DATA = 32;
    localparam int HBIT_DATA = SIZE_DATA - 1;
    localparam int FQ_DEPTH  = 4;
endpackage

// File: rtl/stg1fq.sv
// stg1fq: fetch queue between stg1if and stg2id (registered FIFO of pc/instr pairs)
//   iw_clk/iw_rst          clock, synchronous active-high reset
//   iw_flush               drops every queued entry plus any same-cycle push/pop
//   iw_valid/ow_ready      upstream handshake, iw_pc/iw_instr entry payload
//   ow_valid/iw_ready      downstream handshake, ow_pc/ow_instr head payload
//   ow_count               current occupancy
module stg1fq
    import stg1fq_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                     iw_clk,
    input  logic                     iw_rst,
    input  logic                     iw_flush,
    input  logic                     iw_valid,
    output logic                     ow_ready,
    input  logic [HBIT_ADDR:0]       iw_pc,
    input  logic [HBIT_DATA:0]       iw_instr,
    output logic                     ow_valid,
    input  logic                     iw_ready,
    output logic [HBIT_ADDR:0]       ow_pc,
    output logic [HBIT_DATA:0]       ow_instr,
    output logic [$clog2(DEPTH):0]   ow_count
);
    localparam int AW = $clog2(DEPTH);

    logic [HBIT_ADDR:0] pc_q    [DEPTH];
    logic [HBIT_DATA:0] instr_q [DEPTH];
    logic [AW-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]        count_q, count_d;
    logic               push, pop;

    assign ow_ready = count_q < (AW+1)'(DEPTH);
    assign ow_valid = count_q != '0;
    assign ow_pc    = pc_q[rd_q];
    assign ow_instr = instr_q[rd_q];
    assign ow_count = count_q;

    assign push = iw_valid && ow_ready && !iw_flush;
    assign pop  = ow_valid && iw_ready && !iw_flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        rd_d    = pop  ? rd_q + 1'b1 : rd_q;
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        count_d = (push && !pop) ? count_q + 1'b1 :
                  (pop && !push) ? count_q - 1'b1 : count_q;
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst || iw_flush) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; a write during reset is harmless since pointers clear.
    always_ff @(posedge iw_clk) begin
        if (push && !iw_rst) begin
            pc_q[wr_q]    <= iw_pc;
            instr_q[wr_q] <= iw_instr;
        end
    end
endmodule

// File: tb/tb_stg1fq.sv
// tb_stg1fq: scoreboard bench for the stg1fq fetch queue
module tb_stg1fq;
    import stg1fq_pkg::*;

    localparam logic [31:0] KEY = 32'hDEAD0000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 flush = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic [HBIT_ADDR:0]   in_pc = '0;
    logic [HBIT_DATA:0]   in_instr = '0;
    logic                 ow_ready, ow_valid;
    logic [HBIT_ADDR:0]   ow_pc;
    logic [HBIT_DATA:0]   ow_instr;
    logic [2:0]           ow_count;

    typedef struct {
        logic [HBIT_ADDR:0] pc;
        logic [HBIT_DATA:0] instr;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] got[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_on = 1'b0;

    stg1fq dut (
        .iw_clk(clk), .iw_rst(rst), .iw_flush(flush),
        .iw_valid(in_valid), .ow_ready(ow_ready),
        .iw_pc(in_pc), .iw_instr(in_instr),
        .ow_valid(ow_valid), .iw_ready(out_ready),
        .ow_pc(ow_pc), .ow_instr(ow_instr), .ow_count(ow_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares status every cycle and the head entry whenever it is accepted.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("count", 32'(ow_count), 32'(sb.size()));
            chk("valid", 32'(ow_valid), 32'(sb.size() != 0));
            chk("ready", 32'(ow_ready), 32'(sb.size() < 4));
            if (ow_valid && out_ready && !flush && !rst) begin
                got.push_back(ow_pc);
                if (sb.size() != 0) begin
                    chk("head_pc", ow_pc, sb[0].pc);
                    chk("head_instr", ow_instr, sb[0].instr);
                end
            end
        end
    end

    // Scoreboard update: expected entries are enqueued as the stimulus is accepted.
    always @(posedge clk) begin
        int n;
        n = sb.size();
        if (rst || flush) sb.delete();
        else begin
            if (out_ready && n != 0) void'(sb.pop_front());
            if (in_valid && n < 4) sb.push_back('{in_pc, in_instr});
        end
    end

    task automatic cyc(input bit v, input logic [31:0] pc, input bit r, input bit f);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = pc ^ KEY;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_on = 1'b1;
        chk("rst_valid", 32'(ow_valid), 32'd0);
        chk("rst_ready", 32'(ow_ready), 32'd1);
        chk("rst_count", 32'(ow_count), 32'd0);

        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h10 + i, 1'b0, 1'b0);
        cyc(1'b1, 32'h14, 1'b0, 1'b0);
        chk("full_count", 32'(ow_count), 32'd4);
        chk("full_ready", 32'(ow_ready), 32'd0);
        chk("full_head", ow_pc, 32'h10);

        got.delete();
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_n", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("drain_pc", got[i], 32'h10 + i);
        chk("drain_valid", 32'(ow_valid), 32'd0);

        cyc(1'b1, 32'h20, 1'b0, 1'b0);
        cyc(1'b1, 32'h21, 1'b0, 1'b0);
        got.delete();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'h22 + i, 1'b1, 1'b0);
            chk("pp_count", 32'(ow_count), 32'd2);
        end
        chk("pp_n", 32'(got.size()), 32'd10);
        for (int i = 0; i < 10 && i < got.size(); i++) chk("pp_pc", got[i], 32'h20 + i);

        cyc(1'b1, 32'h30, 1'b0, 1'b0);
        chk("pre_flush", 32'(ow_count), 32'd3);
        cyc(1'b1, 32'h40, 1'b1, 1'b1);
        chk("flush_count", 32'(ow_count), 32'd0);
        got.delete();
        repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush_no_out", 32'(got.size()), 32'd0);

        cyc(1'b1, 32'h50, 1'b0, 1'b0);
        cyc(1'b1, 32'h51, 1'b0, 1'b0);
        got.delete();
        rst = 1'b1;
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        rst = 1'b0;
        chk("rst_mid_pop", 32'(got.size()), 32'd0);
        chk("rst_mid_cnt", 32'(ow_count), 32'd0);
        cyc(1'b1, 32'h80, 1'b0, 1'b0);
        chk("post_rst_valid", 32'(ow_valid), 32'd1);
        chk("post_rst_head", ow_pc, 32'h80);
        chk("post_rst_instr", ow_instr, 32'h80 ^ KEY);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
